// File: rtl/float_adder_param.sv
// Parametrised floating-point adder/subtractor, multi-cycle FSM, one operation in flight.
// Round-to-nearest-even, full subnormal support, flags {invalid, overflow, underflow, inexact}.
module float_adder_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_z,
  output logic [3:0]   out_flags,
  output logic         out_valid,
  input  logic         out_ready
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // out_z/out_flags hold stable while out_valid=1 and out_ready=0.

  localparam int MW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam int EW = EXP_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0]    E_ONE    = EW'(1);
  localparam logic [EW-1:0]    E_INF    = {1'b0, EXP_ONES};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_OUTPUT
  } state_t;

  state_t           state;
  logic [W-1:0]     a_r, b_r;
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_x, b_x;
  logic [MAN_W-1:0] a_f, b_f;
  logic [EW-1:0]    a_e, b_e;
  logic [MW-1:0]    a_m, b_m;
  logic             z_s;
  logic [EW-1:0]    z_e;
  logic [SW-1:0]    sum;
  logic [MAN_W:0]   man_r;
  logic             inexact_r;

  logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic             spec_hit, spec_inv;
  logic [W-1:0]     spec_z;
  logic             a_ge;
  logic [EW-1:0]    e_diff;
  logic [31:0]      sh_amt;
  logic [MW-1:0]    sh_in, sh_mask, sh_out;
  logic             eff_sub, a_big;
  logic [SW-1:0]    sum_next;
  logic             rnd_inc;
  logic [MAN_W+1:0] rnd;
  logic             pack_ovf;
  logic [W-1:0]     pack_z;
  logic [3:0]       pack_flags;

  // Operand classification and special-case result, first match wins.
  always_comb begin
    a_nan  = (a_x == EXP_ONES) && (a_f != '0);
    b_nan  = (b_x == EXP_ONES) && (b_f != '0);
    a_snan = a_nan && !a_f[MAN_W-1];
    b_snan = b_nan && !b_f[MAN_W-1];
    a_inf  = (a_x == EXP_ONES) && (a_f == '0);
    b_inf  = (b_x == EXP_ONES) && (b_f == '0);
    a_zero = (a_x == '0) && (a_f == '0);
    b_zero = (b_x == '0) && (b_f == '0);
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_z   = QNAN;
    if (a_nan || b_nan)                      spec_inv = a_snan || b_snan;
    else if (a_inf && b_inf && (a_s != b_s)) spec_inv = 1'b1;
    else if (a_inf)                          spec_z = a_r;
    else if (b_inf)                          spec_z = b_r;
    else if (a_zero && b_zero)               spec_z = {a_s & b_s, {(W-1){1'b0}}};
    else if (a_zero)                         spec_z = b_r;
    else if (b_zero)                         spec_z = a_r;
    else                                     spec_hit = 1'b0;
  end

  // Alignment: shifted-out bits collapse into the sticky position.
  always_comb begin
    a_ge    = a_e >= b_e;
    e_diff  = a_ge ? (a_e - b_e) : (b_e - a_e);
    sh_amt  = (32'(e_diff) > 32'(MW)) ? 32'(MW) : 32'(e_diff);
    sh_in   = a_ge ? b_m : a_m;
    sh_mask = ~({MW{1'b1}} << sh_amt);
    sh_out  = (sh_in >> sh_amt) | {{(MW-1){1'b0}}, |(sh_in & sh_mask)};
  end

  always_comb begin
    eff_sub = a_s ^ b_s;
    a_big   = a_m >= b_m;
    if (!eff_sub)   sum_next = {1'b0, a_m} + {1'b0, b_m};
    else if (a_big) sum_next = {1'b0, a_m} - {1'b0, b_m};
    else            sum_next = {1'b0, b_m} - {1'b0, a_m};
  end

  // Round to nearest even on {hidden, fraction} with G/R/S in sum[2:0].
  always_comb begin
    rnd_inc = sum[2] && (sum[1] || sum[0] || sum[3]);
    rnd     = {1'b0, sum[SW-2:3]} + (MAN_W+2)'(rnd_inc);
  end

  always_comb begin
    pack_ovf = z_e >= E_INF;
    if (pack_ovf) begin
      pack_z     = {z_s, EXP_ONES, {MAN_W{1'b0}}};
      pack_flags = 4'b0101;
    end else begin
      pack_z     = {z_s, (man_r[MAN_W] ? z_e[EXP_W-1:0] : {EXP_W{1'b0}}), man_r[MAN_W-1:0]};
      pack_flags = {2'b00, !man_r[MAN_W] && inexact_r, inexact_r};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
      a_r       <= '0;
      b_r       <= '0;
      a_s       <= 1'b0;
      b_s       <= 1'b0;
      a_x       <= '0;
      b_x       <= '0;
      a_f       <= '0;
      b_f       <= '0;
      a_e       <= '0;
      b_e       <= '0;
      a_m       <= '0;
      b_m       <= '0;
      z_s       <= 1'b0;
      z_e       <= '0;
      sum       <= '0;
      man_r     <= '0;
      inexact_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b ^ {in_sub, {(W-1){1'b0}}};
            in_ready <= 1'b0;
            state    <= S_UNPACK;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_UNPACK: begin
          a_s   <= a_r[W-1];
          b_s   <= b_r[W-1];
          a_x   <= a_r[W-2:MAN_W];
          b_x   <= b_r[W-2:MAN_W];
          a_f   <= a_r[MAN_W-1:0];
          b_f   <= b_r[MAN_W-1:0];
          a_m   <= {a_r[W-2:MAN_W] != '0, a_r[MAN_W-1:0], 3'b000};
          b_m   <= {b_r[W-2:MAN_W] != '0, b_r[MAN_W-1:0], 3'b000};
          // A zero exponent field carries the same scale as field 1.
          a_e   <= (a_r[W-2:MAN_W] == '0) ? E_ONE : {1'b0, a_r[W-2:MAN_W]};
          b_e   <= (b_r[W-2:MAN_W] == '0) ? E_ONE : {1'b0, b_r[W-2:MAN_W]};
          state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          if (spec_hit) begin
            out_z     <= spec_z;
            out_flags <= {spec_inv, 3'b000};
            out_valid <= 1'b1;
            state     <= S_OUTPUT;
          end else begin
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (a_ge) begin
            b_m <= sh_out;
            z_e <= a_e;
          end else begin
            a_m <= sh_out;
            z_e <= b_e;
          end
          state <= S_ADD;
        end
        S_ADD: begin
          if (eff_sub && (a_m == b_m)) begin
            z_s       <= 1'b0;
            z_e       <= E_ONE;
            man_r     <= '0;
            inexact_r <= 1'b0;
            state     <= S_PACK;
          end else begin
            z_s   <= (eff_sub && !a_big) ? b_s : a_s;
            sum   <= sum_next;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (sum[SW-1]) begin
            sum   <= {1'b0, sum[SW-1:2], sum[1] | sum[0]};
            z_e   <= z_e + E_ONE;
            state <= S_ROUND;
          end else if (!sum[SW-2] && (z_e > E_ONE)) begin
            sum <= sum << 1;
            z_e <= z_e - E_ONE;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          inexact_r <= sum[2] | sum[1] | sum[0];
          if (rnd[MAN_W+1]) begin
            man_r <= rnd[MAN_W+1:1];
            z_e   <= z_e + E_ONE;
          end else begin
            man_r <= rnd[MAN_W:0];
          end
          state <= S_PACK;
        end
        S_PACK: begin
          out_z     <= pack_z;
          out_flags <= pack_flags;
          out_valid <= 1'b1;
          state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_adder_param.sv
// Bench for float_adder_param: a bfloat16 lane and a float32 lane, scoreboards fed by
// directed vectors and by an exact-arithmetic reference model on random operands.
module tb_float_adder_param;

  logic        clk, rst;
  logic [15:0] a0, b0, z0;
  logic [31:0] a1, b1, z1;
  logic        sub0, sub1, v0, v1, ir0, ir1, ov0, ov1, ordy0, ordy1;
  logic [3:0]  f0, f1;
  int          mode0, mode1;
  int          n_tests, n_fail;
  logic [35:0] exp_q0[$];
  logic [35:0] exp_q1[$];

  float_adder_param dut0 (
    .clk(clk), .rst(rst), .in_a(a0), .in_b(b0), .in_sub(sub0), .in_valid(v0),
    .in_ready(ir0), .out_z(z0), .out_flags(f0), .out_valid(ov0), .out_ready(ordy0)
  );

  float_adder_param #(.EXP_W(8), .MAN_W(23)) dut1 (
    .clk(clk), .rst(rst), .in_a(a1), .in_b(b1), .in_sub(sub1), .in_valid(v1),
    .in_ready(ir1), .out_z(z1), .out_flags(f1), .out_valid(ov1), .out_ready(ordy1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: exact sum as a big integer in units of the smallest subnormal, then RNE.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  input int mw, output logic [31:0] z, output logic [3:0] f);
    int w, p, sh;
    logic [31:0] emax, fmask, sbit, qnan, ae, be, af, bf;
    logic as, bs, zs, inx, a_snan, b_snan;
    logic [299:0] ma, mb, mag, one, q, rem, half, enc;
    w = 9 + mw;
    emax = 32'd255;
    fmask = (32'd1 << mw) - 32'd1;
    sbit = 32'd1 << (w - 1);
    as = (a & sbit) != 0;
    bs = ((b & sbit) != 0) ^ sub;
    ae = (a >> mw) & emax;
    be = (b >> mw) & emax;
    af = a & fmask;
    bf = b & fmask;
    qnan = (emax << mw) | (32'd1 << (mw - 1));
    a_snan = (ae == emax) && (af != 0) && (af < (32'd1 << (mw - 1)));
    b_snan = (be == emax) && (bf != 0) && (bf < (32'd1 << (mw - 1)));
    one = 1;
    z = 0;
    f = 0;
    if (((ae == emax) && (af != 0)) || ((be == emax) && (bf != 0))) begin
      z = qnan;
      f = {a_snan || b_snan, 3'b000};
    end else if ((ae == emax) && (be == emax) && (as != bs)) begin
      z = qnan;
      f = 4'b1000;
    end else if (ae == emax) z = a;
    else if (be == emax) z = (bs ? sbit : 0) | (b & ~sbit);
    else if ((ae == 0) && (af == 0) && (be == 0) && (bf == 0)) z = (as && bs) ? sbit : 0;
    else if ((ae == 0) && (af == 0)) z = (bs ? sbit : 0) | (b & ~sbit);
    else if ((be == 0) && (bf == 0)) z = a;
    else begin
      ma = 300'((ae == 0) ? af : (af | (32'd1 << mw))) << ((ae == 0) ? 0 : ae - 1);
      mb = 300'((be == 0) ? bf : (bf | (32'd1 << mw))) << ((be == 0) ? 0 : be - 1);
      if (as == bs) begin mag = ma + mb; zs = as; end
      else if (ma >= mb) begin mag = ma - mb; zs = as; end
      else begin mag = mb - ma; zs = bs; end
      if (mag != 0) begin
        p = 0;
        for (int i = 299; i >= 0; i--) if (mag[i]) begin p = i; break; end
        if (p <= mw) begin
          enc = mag;
          inx = 1'b0;
        end else begin
          sh = p - mw;
          q = mag >> sh;
          rem = mag & ((one << sh) - one);
          half = one << (sh - 1);
          inx = rem != 0;
          if ((rem > half) || ((rem == half) && q[0])) q = q + one;
          enc = (300'(sh) << mw) + q;
        end
        if (enc >= (300'(emax) << mw)) begin
          z = (zs ? sbit : 0) | (emax << mw);
          f = 4'b0101;
        end else begin
          z = (zs ? sbit : 0) | enc[31:0];
          f = {2'b00, inx && (enc < (one << mw)), inx};
        end
      end
    end
  endfunction

  // driver tasks
  task automatic issue(input int lane, input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic push, input logic [31:0] ez, input logic [3:0] ef);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    if (lane == 0) begin a0 = a[15:0]; b0 = b[15:0]; sub0 = sub; v0 = 1'b1; end
    else begin a1 = a; b1 = b; sub1 = sub; v1 = 1'b1; end
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if ((lane == 0) ? ir0 : ir1) begin ok = 1'b1; break; end
    end
    if (ok && push) begin
      if (lane == 0) exp_q0.push_back({ef, ez});
      else exp_q1.push_back({ef, ez});
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout lane%0d: in_ready stayed 0, expected 1", lane);
    end
    @(posedge clk);
    #1;
    if (lane == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic rand_op(input int lane);
    int mw, w, kind;
    logic [31:0] mask, a, b, sp, ez;
    logic [3:0] ef;
    logic sub;
    mw = (lane == 0) ? 7 : 23;
    w = 9 + mw;
    mask = (32'd1 << w) - 32'd1;
    if (w == 32) mask = 32'hFFFF_FFFF;
    a = $urandom & mask;
    b = $urandom & mask;
    kind = $urandom_range(0, 4);
    case (kind)
      1: b = (a ^ 32'($urandom_range(0, 255))) ^ (32'($urandom_range(0, 1)) << (w - 1));
      2: begin
        a = a & ((32'd1 << (mw + 2)) - 1);
        b = b & ((32'd1 << (mw + 2)) - 1);
      end
      3: begin
        case ($urandom_range(0, 3))
          0: sp = 32'd255 << mw;
          1: sp = (32'd255 << mw) | (32'd1 << (mw - 1)) | 32'd1;
          2: sp = (32'd255 << mw) | 32'd1;
          default: sp = 32'd0;
        endcase
        sp = sp | (32'($urandom_range(0, 1)) << (w - 1));
        if ($urandom_range(0, 1) == 1) b = sp;
        else a = sp;
      end
      4: begin
        a = (a & ~(32'd255 << mw)) | (32'd254 << mw);
        b = (b & ~(32'd255 << mw)) | (32'($urandom_range(250, 254)) << mw);
      end
      default: ;
    endcase
    sub = 1'($urandom_range(0, 1));
    ref_add(a, b, sub, mw, ez, ef);
    issue(lane, a, b, sub, 1'b1, ez, ef);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      if ((exp_q0.size() == 0) && (exp_q1.size() == 0)) return;
      @(negedge clk);
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d/%0d pending, expected 0/0", exp_q0.size(), exp_q1.size());
  endtask

  // back-pressure generator
  always @(posedge clk) begin
    #1;
    ordy0 = (mode0 == 0) ? 1'b1 : (mode0 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    ordy1 = (mode1 == 0) ? 1'b1 : (mode1 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // scoreboard monitors
  logic        held0, held1;
  logic [35:0] hv0, hv1;

  task automatic pop_check(input int lane, input logic [35:0] got);
    logic [35:0] e;
    if (((lane == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output lane%0d: got %h, expected no output", lane, got);
    end else begin
      e = (lane == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk((lane == 0) ? "lane0_result" : "lane1_result", 64'(got), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      held0 = 1'b0;
    end else begin
      if (held0) chk("lane0_hold_stable", {ov0, f0, 16'h0, z0}, {1'b1, hv0});
      if (ov0 && ordy0) pop_check(0, {f0, 16'h0, z0});
      held0 = ov0 && !ordy0;
      hv0 = {f0, 16'h0, z0};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      held1 = 1'b0;
    end else begin
      if (held1) chk("lane1_hold_stable", {ov1, f1, z1}, {1'b1, hv1});
      if (ov1 && ordy1) pop_check(1, {f1, z1});
      held1 = ov1 && !ordy1;
      hv1 = {f1, z1};
    end
  end

  // main sequence
  initial begin
    bit seen;
    bit got_valid;
    n_tests = 0;
    n_fail = 0;
    mode0 = 0;
    mode1 = 0;
    ordy0 = 1'b1;
    ordy1 = 1'b1;
    {a0, b0, sub0, v0} = '0;
    {a1, b1, sub1, v1} = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ov0, ir0, f0, z0, ov1, ir1}, '0);
    chk("reset_z1", {f1, z1}, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {ir0, ir1}, 2'b11);

    issue(0, 32'h3F80, 32'h4000, 1'b0, 1'b1, 32'h4040, 4'b0000);
    issue(0, 32'h3F80, 32'h3F80, 1'b1, 1'b1, 32'h0000, 4'b0000);
    issue(0, 32'h3F80, 32'h3B80, 1'b0, 1'b1, 32'h3F80, 4'b0001);
    issue(0, 32'h3F81, 32'h3B80, 1'b0, 1'b1, 32'h3F82, 4'b0001);
    issue(0, 32'h7F80, 32'hFF80, 1'b0, 1'b1, 32'h7FC0, 4'b1000);
    issue(0, 32'h7F7F, 32'h7F7F, 1'b0, 1'b1, 32'h7F80, 4'b0101);
    issue(0, 32'h8000, 32'h8000, 1'b0, 1'b1, 32'h8000, 4'b0000);
    issue(0, 32'h7FA0, 32'h3F80, 1'b0, 1'b1, 32'h7FC0, 4'b1000);
    issue(0, 32'h0001, 32'h0001, 1'b0, 1'b1, 32'h0002, 4'b0000);
    issue(0, 32'h0080, 32'h0001, 1'b1, 1'b1, 32'h007F, 4'b0000);
    issue(1, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 4'b0000);
    drain();

    // back-pressure: result must sit unchanged while out_ready is low
    mode0 = 2;
    issue(0, 32'h3F80, 32'h4000, 1'b0, 1'b1, 32'h4040, 4'b0000);
    got_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ov0) begin got_valid = 1'b1; break; end
    end
    chk("bp_valid_seen", got_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {ov0, ir0, z0}, {1'b1, 1'b0, 16'h4040});
    end
    mode0 = 0;
    drain();

    // reset during normalisation discards the operation
    issue(0, 32'h3F80, 32'h3F7F, 1'b1, 1'b0, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {ov0, ir0}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", ir0, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (ov0) seen = 1'b1;
    end
    chk("abort_no_output", seen, 1'b0);

    mode0 = 1;
    mode1 = 1;
    fork
      for (int i = 0; i < 2000; i++) rand_op(0);
      for (int i = 0; i < 2000; i++) rand_op(1);
    join
    drain();
    repeat (3) @(negedge clk);
    chk("queues_empty", {32'(exp_q0.size()), 32'(exp_q1.size())}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
